// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Counter widths throughout the scanner are derived from keypad_clog2.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } key_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int keypad_clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row driver and column sampler: synchronises the columns, walks the rows and
// presents the completed matrix snapshot together with a one-cycle frame_end.
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 1200
) (
    input  logic                 hwclk,
    input  logic                 rst_n,
    input  logic [COLS-1:0]      col_n,
    output logic [ROWS-1:0]      row_n,
    output logic [ROWS*COLS-1:0] frame_bits,
    output logic                 frame_end
);

    localparam int RW = keypad_clog2(ROWS);
    localparam int DW = keypad_clog2(SCAN_DIV);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_DIV - 1);

    logic [COLS-1:0]      sync1_r;
    logic [COLS-1:0]      sync2_r;
    logic [DW-1:0]        dwell_r;
    logic [RW-1:0]        row_r;
    logic [ROWS-1:0]      row_n_r;
    logic [ROWS*COLS-1:0] snap_r;
    logic [ROWS*COLS-1:0] snap_nx_s;
    logic [RW-1:0]        row_nx_s;
    logic                 last_dwell_s;

    assign last_dwell_s = (dwell_r == LAST_DWELL);
    assign row_nx_s     = (row_r == LAST_ROW) ? {RW{1'b0}} : (row_r + RW'(1'b1));
    assign row_n        = row_n_r;
    assign frame_bits   = snap_nx_s;
    assign frame_end    = last_dwell_s && (row_r == LAST_ROW);

    // Snapshot with the currently driven row merged in on its last dwell cycle.
    always_comb begin
        snap_nx_s = snap_r;
        for (int r = 0; r < ROWS; r++) begin
            if (last_dwell_s && (row_r == RW'(r))) begin
                snap_nx_s[r*COLS +: COLS] = ~sync2_r;
            end else begin
                snap_nx_s[r*COLS +: COLS] = snap_r[r*COLS +: COLS];
            end
        end
    end

    // Column synchroniser, dwell and row counters, row drive and snapshot.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {COLS{1'b1}};
            sync2_r <= {COLS{1'b1}};
            dwell_r <= {DW{1'b0}};
            row_r   <= {RW{1'b0}};
            row_n_r <= ~(ROWS'(1'b1));
            snap_r  <= {(ROWS*COLS){1'b0}};
        end else begin
            sync1_r <= col_n;
            sync2_r <= sync1_r;
            snap_r  <= snap_nx_s;
            if (last_dwell_s) begin
                dwell_r <= {DW{1'b0}};
                row_r   <= row_nx_s;
                row_n_r <= ~(ROWS'(1'b1) << row_nx_s);
            end else begin
                dwell_r <= dwell_r + DW'(1'b1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with frame-based debounce and press/release strobes.
// Define KEYPAD_SCANNER_REPEAT_EN to add auto-repeat of press_pulse while held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SCAN_DIV        = 1200,
    parameter int DEBOUNCE_FRAMES = 25,
    parameter int CODE_W          = 4
`ifdef KEYPAD_SCANNER_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_FRAMES = 1250,
    parameter int REPEAT_RATE_FRAMES  = 250
`endif
) (
    input  logic              hwclk,
    input  logic              rst_n,
    output logic [ROWS-1:0]   row_n,
    input  logic [COLS-1:0]   col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              multi_key
);

    localparam int NKEYS = ROWS * COLS;
    localparam int PW    = keypad_clog2(NKEYS + 1);
    localparam int CW    = keypad_clog2(DEBOUNCE_FRAMES + 2);

    if (CODE_W < keypad_clog2(NKEYS)) begin : g_code_w_check
        $error("keypad_scanner: CODE_W cannot encode ROWS*COLS keys");
    end

    logic [NKEYS-1:0]  frame_bits_s;
    logic              frame_end_s;
    logic [PW-1:0]     pop_s;
    logic [CODE_W-1:0] low_s;
    logic              cand_bit_s;
    logic              single_s;

    key_state_e        state_r, state_nx_s;
    logic [CODE_W-1:0] cand_r, cand_nx_s;
    logic [CW-1:0]     cnt_r, cnt_nx_s, cnt_inc_s;
    logic [CODE_W-1:0] key_code_r, key_code_nx_s;
    logic              key_valid_r, key_valid_nx_s;
    logic              press_r, press_nx_s;
    logic              release_r, release_nx_s;
    logic              multi_r, multi_nx_s;

`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                             REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int RPW = keypad_clog2(REP_MAX + 1);
    logic [RPW-1:0] rep_cnt_r, rep_cnt_nx_s, rep_inc_s;
    logic           rep_first_r, rep_first_nx_s;
    assign rep_inc_s = rep_cnt_r + RPW'(1'b1);
`endif

    keypad_row_scan #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scan (
        .hwclk      (hwclk),
        .rst_n      (rst_n),
        .col_n      (col_n),
        .row_n      (row_n),
        .frame_bits (frame_bits_s),
        .frame_end  (frame_end_s)
    );

    // Frame summary: key count, lowest key index and the candidate's bit.
    always_comb begin
        pop_s      = {PW{1'b0}};
        low_s      = {CODE_W{1'b0}};
        cand_bit_s = 1'b0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            pop_s      = pop_s + PW'(frame_bits_s[i]);
            cand_bit_s = cand_bit_s | ((cand_r == CODE_W'(i)) & frame_bits_s[i]);
            if (frame_bits_s[i]) begin
                low_s = CODE_W'(i);
            end else begin
                low_s = low_s;
            end
        end
    end

    assign single_s  = (pop_s == PW'(1'b1));
    assign cnt_inc_s = cnt_r + CW'(1'b1);

    // Debounce FSM, evaluated once per completed frame.
    always_comb begin
        state_nx_s     = state_r;
        cand_nx_s      = cand_r;
        cnt_nx_s       = cnt_r;
        key_code_nx_s  = key_code_r;
        key_valid_nx_s = key_valid_r;
        press_nx_s     = 1'b0;
        release_nx_s   = 1'b0;
        multi_nx_s     = multi_r;
`ifdef KEYPAD_SCANNER_REPEAT_EN
        rep_cnt_nx_s   = rep_cnt_r;
        rep_first_nx_s = rep_first_r;
`endif
        if (frame_end_s) begin
            multi_nx_s = (pop_s > PW'(1'b1));
            case (state_r)
                IDLE: begin
                    if (single_s) begin
                        state_nx_s = CONFIRM;
                        cand_nx_s  = low_s;
                        cnt_nx_s   = CW'(1'b1);
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                CONFIRM: begin
                    if (single_s && (low_s == cand_r)) begin
                        cnt_nx_s = cnt_inc_s;
                        if (cnt_inc_s >= CW'(DEBOUNCE_FRAMES)) begin
                            state_nx_s     = PRESSED;
                            cnt_nx_s       = {CW{1'b0}};
                            key_code_nx_s  = cand_r;
                            key_valid_nx_s = 1'b1;
                            press_nx_s     = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                            rep_cnt_nx_s   = {RPW{1'b0}};
                            rep_first_nx_s = 1'b0;
`endif
                        end else begin
                            state_nx_s = CONFIRM;
                        end
                    end else begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = {CW{1'b0}};
                    end
                end
                PRESSED: begin
                    if (cand_bit_s) begin
                        state_nx_s = PRESSED;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                        if ((!rep_first_r && (rep_inc_s == RPW'(REPEAT_DELAY_FRAMES))) ||
                            (rep_first_r && (rep_inc_s == RPW'(REPEAT_RATE_FRAMES)))) begin
                            press_nx_s     = 1'b1;
                            rep_cnt_nx_s   = {RPW{1'b0}};
                            rep_first_nx_s = 1'b1;
                        end else begin
                            rep_cnt_nx_s = rep_inc_s;
                        end
`endif
                    end else begin
                        state_nx_s = RELEASE;
                        cnt_nx_s   = CW'(1'b1);
`ifdef KEYPAD_SCANNER_REPEAT_EN
                        rep_cnt_nx_s   = {RPW{1'b0}};
                        rep_first_nx_s = 1'b0;
`endif
                    end
                end
                RELEASE: begin
                    if (!cand_bit_s) begin
                        cnt_nx_s = cnt_inc_s;
                        if (cnt_inc_s >= CW'(DEBOUNCE_FRAMES)) begin
                            state_nx_s     = IDLE;
                            cnt_nx_s       = {CW{1'b0}};
                            key_valid_nx_s = 1'b0;
                            release_nx_s   = 1'b1;
                        end else begin
                            state_nx_s = RELEASE;
                        end
                    end else begin
                        // A bounce during release resumes the held key silently.
                        state_nx_s = PRESSED;
                        cnt_nx_s   = {CW{1'b0}};
`ifdef KEYPAD_SCANNER_REPEAT_EN
                        rep_cnt_nx_s   = {RPW{1'b0}};
                        rep_first_nx_s = 1'b0;
`endif
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cand_r      <= {CODE_W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            key_code_r  <= {CODE_W{1'b0}};
            key_valid_r <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            multi_r     <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt_r   <= {RPW{1'b0}};
            rep_first_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx_s;
            cand_r      <= cand_nx_s;
            cnt_r       <= cnt_nx_s;
            key_code_r  <= key_code_nx_s;
            key_valid_r <= key_valid_nx_s;
            press_r     <= press_nx_s;
            release_r   <= release_nx_s;
            multi_r     <= multi_nx_s;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt_r   <= rep_cnt_nx_s;
            rep_first_r <= rep_first_nx_s;
`endif
        end
    end

    assign key_code      = key_code_r;
    assign key_valid     = key_valid_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign multi_key     = multi_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a D=3 instance checked against a hand-written frame
// table plus a random phase, and a D=1 instance checked against a frame model.
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int NK   = ROWS * COLS;
    localparam int FRAME_CYC = 16;

    logic          hwclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] keys = '0;

    logic [ROWS-1:0] row_n_a, row_n_b;
    logic [COLS-1:0] col_n_a, col_n_b;
    logic [3:0]      key_code_a, key_code_b;
    logic            key_valid_a, key_valid_b;
    logic            press_a, press_b;
    logic            release_a, release_b;
    logic            multi_a, multi_b;

    int tests_run = 0;
    int tests_failed = 0;
    int press_seen[2] = '{0, 0};
    int rel_seen[2]   = '{0, 0};

    // Reference model state per instance (0: D=3, 1: D=1)
    int   m_held[2], m_cand[2], m_streak[2], m_gap[2], m_code[2];
    int   m_ptot[2] = '{0, 0};
    int   m_rtot[2] = '{0, 0};
    logic e_p[2], e_r[2], e_v[2], e_m[2];
    int   e_c[2];

    typedef struct {
        logic [NK-1:0] keys;
        logic          press;
        logic          rel;
        logic          valid;
        logic          multi;
        int            code;
    } vec_t;
    vec_t vecs[$];

    always #5 hwclk = ~hwclk;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .CODE_W(4)
    ) dut (
        .hwclk(hwclk), .rst_n(rst_n), .row_n(row_n_a), .col_n(col_n_a),
        .key_code(key_code_a), .key_valid(key_valid_a), .press_pulse(press_a),
        .release_pulse(release_a), .multi_key(multi_a)
    );

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_FRAMES(1), .CODE_W(4)
    ) dut1 (
        .hwclk(hwclk), .rst_n(rst_n), .row_n(row_n_b), .col_n(col_n_b),
        .key_code(key_code_b), .key_valid(key_valid_b), .press_pulse(press_b),
        .release_pulse(release_b), .multi_key(multi_b)
    );

    // Physical keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n_a = '1;
        col_n_b = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS + c] && !row_n_a[r]) col_n_a[c] = 1'b0;
                if (keys[r*COLS + c] && !row_n_b[r]) col_n_b[c] = 1'b0;
            end
        end
    end

    // Pulse counters.
    always @(posedge hwclk) begin
        if (rst_n) begin
            if (press_a)   press_seen[0] <= press_seen[0] + 1;
            if (press_b)   press_seen[1] <= press_seen[1] + 1;
            if (release_a) rel_seen[0]   <= rel_seen[0] + 1;
            if (release_b) rel_seen[1]   <= rel_seen[1] + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int i, input logic p, input logic r,
                              input logic v, input logic m, input int c);
        if (i == 0) begin
            check({tag, ".press"},   press_a,     p);
            check({tag, ".release"}, release_a,   r);
            check({tag, ".valid"},   key_valid_a, v);
            check({tag, ".multi"},   multi_a,     m);
            check({tag, ".code"},    key_code_a,  c);
        end else begin
            check({tag, ".press"},   press_b,     p);
            check({tag, ".release"}, release_b,   r);
            check({tag, ".valid"},   key_valid_b, v);
            check({tag, ".multi"},   multi_b,     m);
            check({tag, ".code"},    key_code_b,  c);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_held[i] = -1; m_cand[i] = 0; m_streak[i] = 0; m_gap[i] = 0; m_code[i] = 0;
        end
    endtask

    // A key is accepted after a run of max(d,2) identical single-key frames that
    // began from idle, and released after max(d,2) consecutive frames without it.
    task automatic model_step(input int i, input int d, input logic [NK-1:0] m);
        int pop, low, need;
        pop  = $countones(m);
        low  = -1;
        for (int k = NK - 1; k >= 0; k--) if (m[k]) low = k;
        need = (d < 2) ? 2 : d;
        e_p[i] = 1'b0;
        e_r[i] = 1'b0;
        if (m_held[i] < 0) begin
            if (m_streak[i] > 0) begin
                if (pop == 1 && low == m_cand[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] >= need) begin
                        m_held[i] = m_cand[i]; m_code[i] = m_cand[i];
                        m_streak[i] = 0; e_p[i] = 1'b1; m_ptot[i]++;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end else if (pop == 1) begin
                m_cand[i] = low;
                m_streak[i] = 1;
            end
        end else begin
            if (m[m_held[i]]) begin
                m_gap[i] = 0;
            end else begin
                m_gap[i]++;
                if (m_gap[i] >= need) begin
                    m_held[i] = -1; m_gap[i] = 0; e_r[i] = 1'b1; m_rtot[i]++;
                end
            end
        end
        e_v[i] = (m_held[i] >= 0);
        e_m[i] = (pop > 1);
        e_c[i] = m_code[i];
    endtask

    // Runs one frame with the given keys; outputs are sampled just after frame end.
    task automatic do_frame(input logic [NK-1:0] m, input bit cmp0, input bit chk_rows,
                            input string tag);
        logic [ROWS-1:0] exp_row;
        keys = m;
        for (int t = 1; t <= FRAME_CYC; t++) begin
            @(posedge hwclk);
            #1;
            if (chk_rows) begin
                exp_row = ~(4'd1 << ((t / 4) % 4));
                check("row_n", row_n_a, exp_row);
                check("row_n.d1", row_n_b, exp_row);
            end
        end
        model_step(0, 3, m);
        model_step(1, 1, m);
        check_outs({tag, ".d1"}, 1, e_p[1], e_r[1], e_v[1], e_m[1], e_c[1]);
        if (cmp0) check_outs({tag, ".d3"}, 0, e_p[0], e_r[0], e_v[0], e_m[0], e_c[0]);
    endtask

    task automatic add_vec(input logic [NK-1:0] k, input logic p, input logic r,
                           input logic v, input logic m, input int c, input int n);
        vec_t e;
        e.keys = k; e.press = p; e.rel = r; e.valid = v; e.multi = m; e.code = c;
        for (int j = 0; j < n; j++) vecs.push_back(e);
    endtask

    initial begin
        logic [NK-1:0] prev, m;
        int sel, rel_before;

        // Hand-derived frame table for the D=3 instance
        add_vec(12'h000, 0, 0, 0, 0, 0, 10);
        add_vec(12'h080, 0, 0, 0, 0, 0, 2);
        add_vec(12'h080, 1, 0, 1, 0, 7, 1);
        add_vec(12'h080, 0, 0, 1, 0, 7, 3);
        add_vec(12'h000, 0, 0, 1, 0, 7, 2);
        add_vec(12'h000, 0, 1, 0, 0, 7, 1);
        add_vec(12'h000, 0, 0, 0, 0, 7, 1);
        add_vec(12'h001, 0, 0, 0, 0, 7, 2);
        add_vec(12'h000, 0, 0, 0, 0, 7, 1);
        add_vec(12'h022, 0, 0, 0, 1, 7, 2);
        add_vec(12'h002, 0, 0, 0, 0, 7, 2);
        add_vec(12'h002, 1, 0, 1, 0, 1, 1);
        add_vec(12'h000, 0, 0, 1, 0, 1, 2);
        add_vec(12'h000, 0, 1, 0, 0, 1, 1);
        add_vec(12'h010, 0, 0, 0, 0, 1, 2);
        add_vec(12'h010, 1, 0, 1, 0, 4, 1);
        add_vec(12'h000, 0, 0, 1, 0, 4, 1);
        add_vec(12'h010, 0, 0, 1, 0, 4, 2);
        add_vec(12'h000, 0, 0, 1, 0, 4, 2);
        add_vec(12'h000, 0, 1, 0, 0, 4, 1);

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge hwclk);
        #1;
        check("reset.row_n", row_n_a, 4'b1110);
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge hwclk);
        rst_n = 1'b1;

        // Idle frame with row scan order checked each cycle
        do_frame(12'h000, 1'b1, 1'b1, "scan");

        foreach (vecs[v]) begin
            do_frame(vecs[v].keys, 1'b0, 1'b0, $sformatf("vec%0d.d1", v));
            check_outs($sformatf("vec%0d", v), 0, vecs[v].press, vecs[v].rel,
                       vecs[v].valid, vecs[v].multi, vecs[v].code);
        end

        // Reset while a key is held in PRESSED
        do_frame(12'h010, 1'b1, 1'b0, "rst.pre");
        do_frame(12'h010, 1'b1, 1'b0, "rst.pre");
        do_frame(12'h010, 1'b1, 1'b0, "rst.pre");
        check("rst.pre_press", press_a, 1);
        do_frame(12'h010, 1'b1, 1'b0, "rst.held");
        repeat (5) @(posedge hwclk);
        #1;
        rel_before = rel_seen[0];
        rst_n = 1'b0;
        #1;
        check("rst.row_n", row_n_a, 4'b1110);
        check_outs("rst.async", 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge hwclk);
        @(negedge hwclk);
        rst_n = 1'b1;
        check("rst.no_release", rel_seen[0], rel_before);
        do_frame(12'h010, 1'b1, 1'b0, "rst.post");
        do_frame(12'h010, 1'b1, 1'b0, "rst.post");
        check("rst.post_valid", key_valid_a, 0);
        do_frame(12'h010, 1'b1, 1'b0, "rst.post");
        check("rst.post_press", press_a, 1);
        check("rst.post_code", key_code_a, 4);

        // Random frames against the model
        prev = 12'h010;
        for (int f = 0; f < 150; f++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      m = prev;
            else if (sel == 6) m = '0;
            else if (sel == 7) m = 12'd1 << $urandom_range(0, NK - 1);
            else if (sel == 8) m = (12'd1 << $urandom_range(0, NK - 1)) |
                                   (12'd1 << $urandom_range(0, NK - 1));
            else               m = (prev == '0) ? (12'd1 << $urandom_range(0, NK - 1)) : '0;
            do_frame(m, 1'b1, 1'b0, $sformatf("rnd%0d", f));
            prev = m;
        end
        do_frame(12'h000, 1'b1, 1'b0, "tail");
        do_frame(12'h000, 1'b1, 1'b0, "tail");
        do_frame(12'h000, 1'b1, 1'b0, "tail");

        check("total_press.d3", press_seen[0], m_ptot[0]);
        check("total_press.d1", press_seen[1], m_ptot[1]);
        check("total_release.d3", rel_seen[0], m_rtot[0]);
        check("total_release.d1", rel_seen[1], m_rtot[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner and debouncer. Successor to the fixed 3x3 digit-entry block.
- Drives ROWS active-low row lines one at a time and samples COLS pulled-up, active-low column lines, building a full-matrix snapshot per frame.
- Debounces in whole frames and reports one key code with press/release event pulses, a held-level valid flag and a multi-key flag.
- Sits between the keypad pins (column SB_IO pull-ups are instantiated at top level) and the lock-control FSM.

Parameters:
- ROWS, 4, number of row lines (2..8).
- COLS, 3, number of column lines (2..8).
- SCAN_DIV, 1200, hwclk cycles each row is driven low (100 us at 12 MHz).
- DEBOUNCE_FRAMES, 25, consecutive identical frames needed to accept a press or release (~10 ms at defaults).
- CODE_W, 4, key code width; must satisfy 2^CODE_W >= ROWS*COLS (elaboration error otherwise).

Ports:
- hwclk, input, 1, system clock (12 MHz).
- rst_n, input, 1, reset.
- row_n, output, ROWS, row drives; exactly one bit low at any time.
- col_n, input, COLS, raw column inputs (low = pressed on the driven row).
- key_code, output, CODE_W, accepted key index = row*COLS + col.
- key_valid, output, 1, high while the accepted key is held.
- press_pulse, output, 1, one-cycle strobe on key acceptance.
- release_pulse, output, 1, one-cycle strobe on debounced release.
- multi_key, output, 1, previous frame had more than one key down.

Interface: one clock; reset is asynchronous and active-low (clock hwclk, reset rst_n).

Behaviour:
- Reset values: row_n = all ones except bit0 = 0 (row 0 driven); key_code = 0; key_valid, press_pulse, release_pulse, multi_key = 0; FSM IDLE; all counters 0; snapshot cleared.
- Synchroniser: col_n passes through a 2-flop synchroniser before use.
- Row scan:
  - Row index r runs 0..ROWS-1 and wraps to 0.
  - A dwell counter counts 0..SCAN_DIV-1.
  - Synchronised columns are sampled into snapshot row r on the last dwell cycle, after settling; r then advances.
- Frame end: the cycle row ROWS-1 is sampled. The completed snapshot is evaluated; popcount and the lowest set index (row-major) are computed.
- multi_key: updated at each frame end to (popcount > 1).
- FSM transitions, evaluated only at frame end:
  - IDLE: popcount == 1 -> CONFIRM, cand = index, cnt = 1. Otherwise stay.
  - CONFIRM: popcount == 1 and index == cand -> cnt++. When cnt reaches DEBOUNCE_FRAMES -> PRESSED, key_code = cand, key_valid = 1, press_pulse. Any other frame (none, different key, multi) -> IDLE.
  - PRESSED: snapshot bit cand set -> stay (other keys ignored). Bit clear -> RELEASE, cnt = 1.
  - RELEASE: bit cand clear -> cnt++. When cnt reaches DEBOUNCE_FRAMES -> IDLE, key_valid = 0, release_pulse. Bit set -> PRESSED, no pulse.
- Pulse timing: pulses assert in the cycle after the frame end that triggers them, for exactly one cycle.
- key_code holds its last value after release.
- Latency: from a stable press to press_pulse is at most 2 + (DEBOUNCE_FRAMES+1)*ROWS*SCAN_DIV + 1 cycles.
- Reset asserted mid-operation returns everything to reset values immediately, with no release_pulse.
- DEBOUNCE_FRAMES == 1: CONFIRM is accepted on its first repeat frame. Single-frame glitches are still rejected.

Optional Feature:
- Macro: KEYPAD_SCANNER_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY_FRAMES (default 1250) and REPEAT_RATE_FRAMES (default 250).
  - In PRESSED, a frame counter re-issues press_pulse (same key_code) after REPEAT_DELAY_FRAMES, then every REPEAT_RATE_FRAMES, while bit cand stays set.
  - The counter clears on entering PRESSED or RELEASE.
- Undefined: exactly one press_pulse per accepted press, and no repeat logic or parameters exist.

Decomposition:
- Package keypad_pkg:
  - FSM state enum (IDLE, CONFIRM, PRESSED, RELEASE).
  - clog2-style constant function used for counter widths and the CODE_W check.
- Sub-module keypad_row_scan: synchroniser, dwell/row counters, row_n drive, snapshot register and frame_end strobe. The parent holds the FSM and outputs.

Test Plan (ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16-cycle frames):
- Reset release, no keys -> row_n cycles 1110, 1101, 1011, 0111, 4 cycles each; all outputs stay 0 for 10 frames.
- Key row2/col1 held for 6 frames -> press_pulse once with key_code = 7 and key_valid = 1. After release, release_pulse follows 3 frames later and key_code stays 7.
- Key row0/col0 held for 2 frames only (bounce) -> no press_pulse; FSM returns to IDLE.
- Keys 1 and 5 held together from idle -> multi_key = 1, no press_pulse. Release key 5 -> press_pulse with key_code = 1 after 3 frames.
- Key 4 accepted, then released for 1 frame and re-pressed -> no release_pulse or second press_pulse; key_valid stays 1.
- rst_n pulsed low while in PRESSED -> outputs return to reset values asynchronously, no release_pulse; with the key still held after reset, press_pulse is re-issued after the debounce time.
